// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses pll_rst, qualifies lock, then releases rst_out_0 before rst_out_1.
// All outputs are registered; lock input is double-flopped before the FSM looks at it.
module pll_reset_sequencer #(
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned RELEASE_GAP_CYCLES  = 8
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       rst_out_0,
    output logic       rst_out_1,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] retry_cnt
);

    localparam int unsigned MAX_AB  = (LOCK_STABLE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                      LOCK_STABLE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_CD  = (PLL_RST_CYCLES > RELEASE_GAP_CYCLES) ?
                                      PLL_RST_CYCLES : RELEASE_GAP_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(RELEASE_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_PLL_RESET = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             pll_rst_q, pll_rst_d;
    logic             rst_out_0_q, rst_out_0_d;
    logic             rst_out_1_q, rst_out_1_d;
    logic             ready_q, ready_d;
    logic             lock_lost_q, lock_lost_d;
    logic [7:0]       retry_q, retry_d;
    logic             locked_s;

    assign locked_s = sync2_q;

    always_comb begin
        sync1_d     = pll_locked;
        sync2_d     = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        lock_lost_d = lock_lost_q;
        retry_d     = retry_q;

        unique case (state_q)
            S_PLL_RESET: begin
                if (cnt_q == PLL_RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (locked_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_PLL_RESET;
                    if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
                end
            end
            S_STABLE: begin
                if (!locked_s)                  state_d = S_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST)  state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!locked_s)                  state_d = S_WAIT_LOCK;
                else if (cnt_q == GAP_LAST)     state_d = S_RUN;
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d     = S_WAIT_LOCK;
                    lock_lost_d = 1'b1;
                end
            end
            default: state_d = S_PLL_RESET;
        endcase

        if (state_d != state_q) cnt_d = '0;

        // Outputs are decoded from the next state so they change on the transition edge.
        pll_rst_d   = (state_d == S_PLL_RESET);
        rst_out_0_d = !((state_d == S_RELEASE) || (state_d == S_RUN));
        rst_out_1_d = (state_d != S_RUN);
        ready_d     = (state_d == S_RUN);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= S_PLL_RESET;
            cnt_q       <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            pll_rst_q   <= 1'b1;
            rst_out_0_q <= 1'b1;
            rst_out_1_q <= 1'b1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            retry_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            pll_rst_q   <= pll_rst_d;
            rst_out_0_q <= rst_out_0_d;
            rst_out_1_q <= rst_out_1_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
            retry_q     <= retry_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign rst_out_0 = rst_out_0_q;
    assign rst_out_1 = rst_out_1_q;
    assign ready     = ready_q;
    assign lock_lost = lock_lost_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters.
module tb_pll_reset_sequencer;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       rst_out_0;
    logic       rst_out_1;
    logic       ready;
    logic       lock_lost;
    logic [7:0] retry_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 refclk = ~refclk;

    pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES (16),
        .LOCK_TIMEOUT_CYCLES(100),
        .PLL_RST_CYCLES     (4),
        .RELEASE_GAP_CYCLES (4)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .pll_rst   (pll_rst),
        .rst_out_0 (rst_out_0),
        .rst_out_1 (rst_out_1),
        .ready     (ready),
        .lock_lost (lock_lost),
        .retry_cnt (retry_cnt)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n falling edges, checking the reset-ordering invariants at each one.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge refclk);
            chk("inv_rst1_implies_rst0", {7'd0, (rst_out_1 === 1'b0) && (rst_out_0 !== 1'b0)}, 8'd0);
            chk("inv_rst0_vs_pll_rst", {7'd0, (rst_out_0 === 1'b0) && (pll_rst === 1'b1)}, 8'd0);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_rst"},   {7'd0, pll_rst},   8'd1);
        chk({tag, "_rst_out_0"}, {7'd0, rst_out_0}, 8'd1);
        chk({tag, "_rst_out_1"}, {7'd0, rst_out_1}, 8'd1);
        chk({tag, "_ready"},     {7'd0, ready},     8'd0);
        chk({tag, "_lock_lost"}, {7'd0, lock_lost}, 8'd0);
        chk({tag, "_retry_cnt"}, retry_cnt,         8'd0);
    endtask

    initial begin
        int   n;
        logic pll_seen;

        // Reset state
        step(3);
        chk_reset_vals("reset");
        rst = 1'b0;

        // Nominal bring-up
        step(3);
        chk("nom_pll_rst_held", {7'd0, pll_rst}, 8'd1);
        step(1);
        chk("nom_pll_rst_fall", {7'd0, pll_rst}, 8'd0);
        chk("nom_rst0_held", {7'd0, rst_out_0}, 8'd1);
        step(6);
        pll_locked = 1'b1;
        step(18);
        chk("nom_rst0_before", {7'd0, rst_out_0}, 8'd1);
        step(1);
        chk("nom_rst0_fall", {7'd0, rst_out_0}, 8'd0);
        chk("nom_rst1_held", {7'd0, rst_out_1}, 8'd1);
        chk("nom_pll_rst_low", {7'd0, pll_rst}, 8'd0);
        step(3);
        chk("nom_rst1_before", {7'd0, rst_out_1}, 8'd1);
        chk("nom_ready_before", {7'd0, ready}, 8'd0);
        step(1);
        chk("nom_rst1_fall", {7'd0, rst_out_1}, 8'd0);
        chk("nom_ready", {7'd0, ready}, 8'd1);
        chk("nom_retry", retry_cnt, 8'd0);

        // Loss of lock in RUN, then recovery without a PLL pulse
        pll_locked = 1'b0;
        step(2);
        chk("loss_ready_still", {7'd0, ready}, 8'd1);
        step(1);
        chk("loss_rst0", {7'd0, rst_out_0}, 8'd1);
        chk("loss_rst1", {7'd0, rst_out_1}, 8'd1);
        chk("loss_ready", {7'd0, ready}, 8'd0);
        chk("loss_lock_lost", {7'd0, lock_lost}, 8'd1);
        chk("loss_pll_rst", {7'd0, pll_rst}, 8'd0);
        pll_locked = 1'b1;
        pll_seen = 1'b0;
        for (int i = 0; i < 18; i++) begin
            step(1);
            pll_seen = pll_seen | pll_rst;
        end
        chk("rerel_rst0_before", {7'd0, rst_out_0}, 8'd1);
        step(1);
        chk("rerel_rst0_fall", {7'd0, rst_out_0}, 8'd0);
        chk("rerel_no_pll_pulse", {7'd0, pll_seen}, 8'd0);
        step(4);
        chk("rerel_ready", {7'd0, ready}, 8'd1);
        chk("rerel_lock_lost_sticky", {7'd0, lock_lost}, 8'd1);

        // Glitchy lock aborts STABLE
        rst = 1'b1;
        pll_locked = 1'b0;
        step(2);
        rst = 1'b0;
        step(4);
        chk("glitch_pll_rst_fall", {7'd0, pll_rst}, 8'd0);
        pll_locked = 1'b1;
        step(10);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(8);
        chk("glitch_no_early_release", {7'd0, rst_out_0}, 8'd1);
        step(10);
        chk("glitch_rst0_before", {7'd0, rst_out_0}, 8'd1);
        step(1);
        chk("glitch_rst0_fall", {7'd0, rst_out_0}, 8'd0);

        // Timeouts and retry saturation
        rst = 1'b1;
        pll_locked = 1'b0;
        step(2);
        rst = 1'b0;
        step(103);
        chk("to_pll_rst_before", {7'd0, pll_rst}, 8'd0);
        chk("to_retry_before", retry_cnt, 8'd0);
        step(1);
        chk("to1_pll_rst", {7'd0, pll_rst}, 8'd1);
        chk("to1_retry", retry_cnt, 8'd1);
        step(3);
        chk("to1_pulse_held", {7'd0, pll_rst}, 8'd1);
        step(1);
        chk("to1_pulse_end", {7'd0, pll_rst}, 8'd0);
        step(100);
        chk("to2_pll_rst", {7'd0, pll_rst}, 8'd1);
        chk("to2_retry", retry_cnt, 8'd2);
        step(104);
        chk("to3_pll_rst", {7'd0, pll_rst}, 8'd1);
        chk("to3_retry", retry_cnt, 8'd3);
        step(104 * 252);
        chk("to255_retry", retry_cnt, 8'd255);
        step(104 * 48);
        chk("to_sat_retry", retry_cnt, 8'd255);

        // Reach RUN, lose lock, then async reset mid-RELEASE
        pll_locked = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            step(1);
            n++;
        end
        chk("sat_run_ready", {7'd0, ready}, 8'd1);
        chk("sat_run_retry", retry_cnt, 8'd255);
        pll_locked = 1'b0;
        step(3);
        chk("sat_loss_lock_lost", {7'd0, lock_lost}, 8'd1);
        pll_locked = 1'b1;
        n = 0;
        while (rst_out_0 !== 1'b0 && n < 100) begin
            step(1);
            n++;
        end
        chk("mid_rel_rst0", {7'd0, rst_out_0}, 8'd0);
        chk("mid_rel_rst1", {7'd0, rst_out_1}, 8'd1);
        @(posedge refclk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async");

        // Lock arrives on the timeout cycle
        pll_locked = 1'b0;
        step(2);
        rst = 1'b0;
        step(101);
        pll_locked = 1'b1;
        step(2);
        chk("col_pll_rst_pre", {7'd0, pll_rst}, 8'd0);
        step(1);
        chk("col_no_pll_pulse", {7'd0, pll_rst}, 8'd0);
        chk("col_retry", retry_cnt, 8'd0);
        step(15);
        chk("col_rst0_before", {7'd0, rst_out_0}, 8'd1);
        step(1);
        chk("col_rst0_fall", {7'd0, rst_out_0}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Drives the PLL reset input and consumes the PLL lock indication.
- Qualifies lock for a programmable stable time, then releases two downstream reset outputs in order: the 48 MHz domain first, then the 15 MHz domain.
- On lock timeout it re-pulses the PLL reset and retries. On loss of lock it re-asserts the downstream resets.
- Runs on the 50 MHz board reference clock and sits between the board reset pin, the system PLL, and the core reset tree.

Parameters:
LOCK_STABLE_CYCLES, 1024, refclk cycles the synchronized lock must stay high before the first reset release (>=2).
LOCK_TIMEOUT_CYCLES, 50000, refclk cycles to wait for lock before re-pulsing the PLL reset (1 ms at 50 MHz; >=2).
PLL_RST_CYCLES, 16, width of each pll_rst pulse in refclk cycles (>=2).
RELEASE_GAP_CYCLES, 8, refclk cycles between rst_out_0 and rst_out_1 deassertion (>=2).

Ports:
refclk  in  1  50 MHz reference clock; the single clock of this block.
rst  in  1  asynchronous, active-high reset (board reset).
pll_locked  in  1  PLL lock indication; asynchronous, synchronized internally.
pll_rst  out  1  active-high reset to the PLL.
rst_out_0  out  1  active-high reset for the outclk_0 (48 MHz) domain.
rst_out_1  out  1  active-high reset for the outclk_1 (15 MHz) domain.
ready  out  1  high when both resets are released and lock is held.
lock_lost  out  1  sticky; set on any loss of lock after reaching RUN.
retry_cnt  out  8  number of lock timeouts; saturates at 255.

Behaviour:
- All outputs are registered. Reset assertion is asynchronous; deassertion is synchronous to refclk.
- Reset values:
  - pll_rst=1, rst_out_0=1, rst_out_1=1
  - ready=0, lock_lost=0, retry_cnt=0
  - state=PLL_RESET, cnt=0, synchronizer flops=0
- pll_locked passes through a 2-flop synchronizer to produce locked_s. Total input-to-locked_s latency is 2 edges. The FSM uses only locked_s.
- cnt is a single shared counter, sized to clog2 of the largest parameter, and cleared on every state change.
- PLL_RESET:
  - pll_rst=1, both rst_out=1, ready=0.
  - At cnt==PLL_RST_CYCLES-1, go to WAIT_LOCK; pll_rst=0 from that edge.
- WAIT_LOCK:
  - pll_rst=0, both rst_out=1.
  - If locked_s=1, go to STABLE.
  - Else if cnt==LOCK_TIMEOUT_CYCLES-1, go to PLL_RESET and increment retry_cnt (saturating).
- STABLE:
  - If locked_s=0, go to WAIT_LOCK; the timeout restarts from 0.
  - Else at cnt==LOCK_STABLE_CYCLES-1, go to RELEASE; rst_out_0=0 from that edge.
- RELEASE:
  - rst_out_0=0, rst_out_1=1.
  - At cnt==RELEASE_GAP_CYCLES-1, go to RUN; rst_out_1=0 and ready=1 from that edge.
- RUN: hold. rst_out_0=0, rst_out_1=0, ready=1.
- Loss of lock (locked_s=0) in RELEASE or RUN:
  - At the next edge: both rst_out=1, ready=0, go to WAIT_LOCK.
  - lock_lost is set only when the loss occurs in RUN.
  - The PLL is not reset; pll_rst stays 0.
- Simultaneous events:
  - In WAIT_LOCK, locked_s=1 on the timeout cycle: lock wins, go to STABLE, retry_cnt unchanged.
  - In STABLE, locked_s=0 on the final count: loss wins, go to WAIT_LOCK.
- rst asserted in any state: immediate return to the reset values. lock_lost and retry_cnt clear.
- rst_out_0 and rst_out_1 are synchronized into their own clock domains by receiving logic. This block only guarantees ordering and gap in refclk cycles.
- Invariant, checked by assertion: rst_out_1=0 implies rst_out_0=0. rst_out_0 never deasserts while pll_rst=1.

Test Plan (LOCK_STABLE_CYCLES=16, LOCK_TIMEOUT_CYCLES=100, PLL_RST_CYCLES=4, RELEASE_GAP_CYCLES=4):
- Nominal bring-up: release rst, pll_locked=1 from cycle 10 -> pll_rst falls after 4 cycles; rst_out_0 falls 2+16 edges after lock sampling; rst_out_1 and ready rise/fall 4 edges later; retry_cnt=0.
- Timeout: pll_locked held 0 -> pll_rst re-pulses for 4 cycles every 104 cycles; retry_cnt counts 1, 2, 3. Force 300 timeouts -> retry_cnt holds at 255.
- Glitchy lock: lock high 10 cycles, low 1, high again -> STABLE aborts; rst_out_0 falls 16 cycles after the second qualification, not the first.
- Loss in RUN: drop pll_locked in RUN -> both rst_out=1 and ready=0 within 3 edges; lock_lost=1; pll_rst stays 0. Restore lock -> re-release without a PLL pulse.
- Collision: locked_s rises on cycle 99 of WAIT_LOCK -> enters STABLE, no pll_rst pulse, retry_cnt unchanged.
- Async reset mid-RELEASE: assert rst between clock edges -> all outputs return to reset values immediately, without waiting for an edge; lock_lost=0, retry_cnt=0.
